// File: rtl/tt_check_pkg.sv
// Shared types and cell-library truth tables for the truth-table checker.
package tt_check_pkg;

  // Checker sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  // Width of the settle counter; covers SETTLE up to 15
  localparam int unsigned SETTLE_W = 4;

  // Expected truth tables, bit i = output for input vector i
  localparam logic [3:0] NAND2_TT = 4'b0111;
  localparam logic [7:0] NAND3_TT = 8'b0111_1111;
  localparam logic [7:0] NOR3_TT  = 8'b0000_0001;
  localparam logic [7:0] AND3_TT  = 8'b1000_0000;

  // Final settle count; a zero settle still holds each vector for one cycle
  function automatic int unsigned settle_last(input int unsigned settle);
    return (settle == 0) ? 0 : settle - 1;
  endfunction

endpackage

// File: rtl/tt_vector_counter.sv
// Vector index and per-vector settle counters for the truth-table checker.
module tt_vector_counter
  import tt_check_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            settle_inc,
  input  logic            vec_inc,
  output logic [N_IN-1:0] vec,
  output logic            last_vec,
  output logic            settle_done
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(settle_last(SETTLE));
  localparam logic [N_IN-1:0]     VEC_LAST    = '1;

  logic [SETTLE_W-1:0] settle_cnt;

  // Clear wins over advancing to the next vector, which wins over settling
  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      vec        <= '0;
      settle_cnt <= '0;
    end else if (vec_inc) begin
      vec        <= vec + N_IN'(1);
      settle_cnt <= '0;
    end else if (settle_inc) begin
      settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  assign last_vec    = (vec == VEC_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive stimulus generator and response checker for one combinational cell.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int unsigned           N_IN   = 3,
  parameter int unsigned           SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = NAND3_TT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid,
  output logic            sample_valid,
  output logic [N_IN-1:0] sample_vec
);

  localparam int unsigned CW = N_IN + 1;

  tt_state_e       state;
  logic [N_IN-1:0] vec;
  logic            last_vec;
  logic            settle_done;
  logic            start_ok;
  logic            mismatch;
  logic [CW-1:0]   err_next;

  // Start is honoured only when no run is in flight
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Case-inequality so an X/Z response is flagged as a failure in simulation
  assign mismatch = (state == ST_SAMPLE) && (dut_out !== EXPECT[vec]);
  assign err_next = err_count + CW'(mismatch);

  tt_vector_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok),
    .settle_inc  (state == ST_APPLY),
    .vec_inc     ((state == ST_SAMPLE) && !last_vec),
    .vec         (vec),
    .last_vec    (last_vec),
    .settle_done (settle_done)
  );

  // The vector register drives the cell directly and holds the last vector in DONE
  assign dut_in = vec;

  // Run sequencing, compare accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      sample_valid    <= 1'b0;
      sample_vec      <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_APPLY;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (settle_done) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          sample_valid <= 1'b1;
          sample_vec   <= vec;
          err_count    <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_vec   <= vec;
            first_err_valid <= 1'b1;
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
